// File: rtl/semimips_pkg.sv
// Shared definitions for the semiMIPS pipeline control blocks:
// sequencing state encoding and the default memory-timeout threshold.
package semimips_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } seq_state_t;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNTW    = 16;

  // Load-use compare shared by the hazard detector and the decoder; $0 never stalls.
  function automatic logic loaduse_hit(
    input logic       ldrd,
    input logic [4:0] ldrt,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       usert
  );
    return ldrd && (ldrt != 5'd0) && ((ldrt == rs) || (usert && (ldrt == rt)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use hazard detector between ID/EX and IF/ID.
module hazard_detect
  import semimips_pkg::*;
(
  input  logic       idexmemrd,
  input  logic [4:0] idexrt,
  input  logic [4:0] ifidrs,
  input  logic [4:0] ifidrt,
  input  logic       ifidusert,
  output logic       loaduse
);

  assign loaduse = loaduse_hit(idexmemrd, idexrt, ifidrs, ifidrt, ifidusert);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage write enables and flushes for the
// 5-stage semiMIPS core, plus stall counter and data-memory timeout watchdog.
module pipeline_hazard_ctrl
  import semimips_pkg::*;
#(
  parameter int CNTW    = DEF_CNTW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idexmemrd,
  input  logic [4:0]      idexrt,
  input  logic [4:0]      ifidrs,
  input  logic [4:0]      ifidrt,
  input  logic            ifidusert,
  input  logic            exbranch,
  input  logic            idjump,
  input  logic            exmemmemrd,
  input  logic            exmemmemwr,
  input  logic            dmemready,
  input  logic            imemready,
  output logic            pcwr,
  output logic            ifidwr,
  output logic            ifidflush,
  output logic            idexwr,
  output logic            idexflush,
  output logic            exmemwr,
  output logic            memwbwr,
  output logic [CNTW-1:0] stallcount,
  output logic            memtimeout
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO_W = WCW'(TIMEOUT);

  seq_state_t      state_r, state_nx_s;
  logic [WCW-1:0]  waitcnt_r, waitcnt_nx_s;
  logic [CNTW-1:0] stallcount_r;
  logic            memtimeout_r;
  logic            loaduse_s, dfreeze_s, ifreeze_s;
  logic            pcwr_s, ifidwr_s, ifidflush_s, idexwr_s, idexflush_s, exmemwr_s, memwbwr_s;

  hazard_detect u_hazard_detect (
    .idexmemrd (idexmemrd),
    .idexrt    (idexrt),
    .ifidrs    (ifidrs),
    .ifidrt    (ifidrt),
    .ifidusert (ifidusert),
    .loaduse   (loaduse_s)
  );

  assign dfreeze_s = (exmemmemrd | exmemmemwr) & ~dmemready;
  assign ifreeze_s = ~imemready & ~dfreeze_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a simultaneous data and instruction wait resolves to DWAIT.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      RUN: begin
        if (dfreeze_s) begin
          state_nx_s = DWAIT;
        end else if (ifreeze_s) begin
          state_nx_s = IWAIT;
        end else begin
          state_nx_s = RUN;
        end
      end
      DWAIT: begin
        if (dmemready) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = DWAIT;
        end
      end
      IWAIT: begin
        if (dfreeze_s) begin
          state_nx_s = DWAIT;
        end else if (imemready) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IWAIT;
        end
      end
      default: state_nx_s = RUN;
    endcase
  end

  // Mealy stage controls: reset, data freeze, branch, load-use/fetch wait, jump, default.
  always_comb begin
    pcwr_s      = 1'b1;
    ifidwr_s    = 1'b1;
    ifidflush_s = 1'b0;
    idexwr_s    = 1'b1;
    idexflush_s = 1'b0;
    exmemwr_s   = 1'b1;
    memwbwr_s   = 1'b1;
    if (rst) begin
      pcwr_s      = 1'b0;
      ifidwr_s    = 1'b0;
      ifidflush_s = 1'b1;
      idexwr_s    = 1'b0;
      idexflush_s = 1'b1;
      exmemwr_s   = 1'b0;
      memwbwr_s   = 1'b0;
    end else if (dfreeze_s) begin
      pcwr_s    = 1'b0;
      ifidwr_s  = 1'b0;
      idexwr_s  = 1'b0;
      exmemwr_s = 1'b0;
      memwbwr_s = 1'b0;
    end else if (exbranch) begin
      ifidflush_s = 1'b1;
      idexflush_s = 1'b1;
    end else if (loaduse_s || ifreeze_s) begin
      pcwr_s      = 1'b0;
      ifidwr_s    = 1'b0;
      idexflush_s = 1'b1;
    end else if (idjump) begin
      ifidflush_s = 1'b1;
    end else begin
      pcwr_s = 1'b1;
    end
  end

  // Watchdog count: only DWAIT cycles still waiting on memory; cleared on leaving DWAIT.
  always_comb begin
    waitcnt_nx_s = waitcnt_r;
    if ((state_r == DWAIT) && (state_nx_s == DWAIT)) begin
      if (!dmemready && (waitcnt_r != TMO_W)) begin
        waitcnt_nx_s = waitcnt_r + WCW'(1);
      end else begin
        waitcnt_nx_s = waitcnt_r;
      end
    end else begin
      waitcnt_nx_s = '0;
    end
  end

  // Watchdog, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitcnt_r    <= '0;
      memtimeout_r <= 1'b0;
      stallcount_r <= '0;
    end else begin
      waitcnt_r    <= waitcnt_nx_s;
      memtimeout_r <= memtimeout_r | (waitcnt_nx_s == TMO_W);
      if (!pcwr_s && (stallcount_r != {CNTW{1'b1}})) begin
        stallcount_r <= stallcount_r + CNTW'(1);
      end else begin
        stallcount_r <= stallcount_r;
      end
    end
  end

  assign pcwr       = pcwr_s;
  assign ifidwr     = ifidwr_s;
  assign ifidflush  = ifidflush_s;
  assign idexwr     = idexwr_s;
  assign idexflush  = idexflush_s;
  assign exmemwr    = exmemwr_s;
  assign memwbwr    = memwbwr_s;
  assign stallcount = stallcount_r;
  assign memtimeout = memtimeout_r;

endmodule
